gshare_bht: RTL

Parametrised gshare branch predictor for the fetch stage. It is the next generation of the two-bit per-PC history table. Each table index is the PC XORed with a global history register (GHR). Counter width, depth and history length are configurable. The GHR is updated speculatively on every accepted prediction and repaired on mispredict. The table is cleared by a sequential init sweep, so it maps onto single-write-port RAM.

---
 rtl/gshare_bht_pkg.sv | 44 ++++
 rtl/gshare_bht_table.sv | 56 +++++
 rtl/gshare_bht.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gshare_bht_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
// Counters are handled at a fixed maximum width and sliced down by the user.
package gshare_bht_pkg;

   localparam int unsigned CTR_MAX_W = 16;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Saturating up/down step of a width-bit counter held in the low bits.
   function automatic logic [CTR_MAX_W-1:0] ctr_next(
      input logic [CTR_MAX_W-1:0] ctr,
      input logic                 taken,
      input int unsigned          width
   );
      logic [CTR_MAX_W-1:0] max_v;
      if (width >= CTR_MAX_W) begin
         max_v = {CTR_MAX_W{1'b1}};
      end else begin
         max_v = (CTR_MAX_W'(1) << width) - CTR_MAX_W'(1);
      end
      if (taken) begin
         if (ctr >= max_v) begin
            return ctr;
         end else begin
            return ctr + CTR_MAX_W'(1);
         end
      end else begin
         if (ctr == CTR_MAX_W'(0)) begin
            return ctr;
         end else begin
            return ctr - CTR_MAX_W'(1);
         end
      end
   endfunction

   // Weakly-taken starting value: only the MSB set.
   function automatic logic [CTR_MAX_W-1:0] ctr_init(input int unsigned width);
      return CTR_MAX_W'(1) << (width - 1);
   endfunction

endpackage

// File: rtl/gshare_bht_table.sv
// Counter storage: two asynchronous read ports and one synchronous write port,
// with the init sweep taking priority over training updates on the write port.
module gshare_bht_table
   import gshare_bht_pkg::*;
#(
   parameter int NUM_ENTRIES = 16,
   parameter int CTR_WIDTH   = 2,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic                 CLK,
   input  logic                 init_en,
   input  logic [IDX_W-1:0]     init_idx,
   input  logic [CTR_WIDTH-1:0] init_val,
   input  logic                 upd_en,
   input  logic [IDX_W-1:0]     upd_idx,
   input  logic [CTR_WIDTH-1:0] upd_val,
   input  logic [IDX_W-1:0]     rd_pred_idx,
   output logic [CTR_WIDTH-1:0] rd_pred_ctr,
   input  logic [IDX_W-1:0]     rd_res_idx,
   output logic [CTR_WIDTH-1:0] rd_res_ctr
);

   logic [CTR_WIDTH-1:0] mem_r [NUM_ENTRIES];
   logic                 wr_en_s;
   logic [IDX_W-1:0]     wr_idx_s;
   logic [CTR_WIDTH-1:0] wr_val_s;

   // Single write port shared between the sweep and training.
   always_comb begin
      wr_en_s  = 1'b0;
      wr_idx_s = '0;
      wr_val_s = '0;
      if (init_en) begin
         wr_en_s  = 1'b1;
         wr_idx_s = init_idx;
         wr_val_s = init_val;
      end else if (upd_en) begin
         wr_en_s  = 1'b1;
         wr_idx_s = upd_idx;
         wr_val_s = upd_val;
      end else begin
         wr_en_s  = 1'b0;
      end
   end

   // Storage array; no reset so it maps onto plain RAM.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_val_s;
      end
   end

   assign rd_pred_ctr = mem_r[rd_pred_idx];
   assign rd_res_ctr  = mem_r[rd_res_idx];

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch predictor: PC xor global history indexes a table of saturating
// counters; history is shifted speculatively and repaired on mispredict.
module gshare_bht
   import gshare_bht_pkg::*;
#(
   parameter int NUM_ENTRIES = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int HIST_WIDTH  = 4,
   parameter int CTR_WIDTH   = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PRED_VALID,
   input  logic [ADDR_WIDTH-1:0] PC_IN_PRED,
   input  logic [ADDR_WIDTH-1:0] SKIP_OFF_IN,
   input  logic [ADDR_WIDTH-1:0] TAKE_OFF_IN,
   output logic                  PRED_READY,
   output logic [ADDR_WIDTH-1:0] TAKE_OUT,
   output logic                  PRED_TAKEN,
   output logic [HIST_WIDTH-1:0] PRED_HIST,
   input  logic                  RES_VALID,
   input  logic [ADDR_WIDTH-1:0] PC_IN_RES,
   input  logic                  TAKE_IN,
   input  logic [HIST_WIDTH-1:0] RES_HIST,
   input  logic                  MISPRED
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   state_e               state_r;
   logic [IDX_W-1:0]     ptr_r;
   logic [HIST_WIDTH-1:0] ghr_r;
   logic [HIST_WIDTH-1:0] ghr_nxt_s;

   logic                 run_s;
   logic [IDX_W-1:0]     idx_p_s;
   logic [IDX_W-1:0]     idx_r_s;
   logic [CTR_WIDTH-1:0] pred_ctr_s;
   logic [CTR_WIDTH-1:0] res_ctr_s;
   logic [CTR_MAX_W-1:0] upd_wide_s;
   logic [CTR_MAX_W-1:0] init_wide_s;
   logic                 pred_taken_s;
   logic                 init_en_s;
   logic                 upd_en_s;
   logic                 unused_s;

   assign run_s   = (state_r == ST_RUN);
   assign idx_p_s = PC_IN_PRED[IDX_W-1:0] ^ IDX_W'(ghr_r);
   assign idx_r_s = PC_IN_RES[IDX_W-1:0] ^ IDX_W'(RES_HIST);

   // RST is checked here too so a reset cycle never disturbs the table.
   assign init_en_s = ~RST & ~run_s;
   assign upd_en_s  = ~RST & run_s & RES_VALID;

   assign upd_wide_s  = ctr_next(CTR_MAX_W'(res_ctr_s), TAKE_IN, CTR_WIDTH);
   assign init_wide_s = ctr_init(CTR_WIDTH);

   gshare_bht_table #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .CTR_WIDTH   (CTR_WIDTH),
      .IDX_W       (IDX_W)
   ) u_table (
      .CLK         (CLK),
      .init_en     (init_en_s),
      .init_idx    (ptr_r),
      .init_val    (init_wide_s[CTR_WIDTH-1:0]),
      .upd_en      (upd_en_s),
      .upd_idx     (idx_r_s),
      .upd_val     (upd_wide_s[CTR_WIDTH-1:0]),
      .rd_pred_idx (idx_p_s),
      .rd_pred_ctr (pred_ctr_s),
      .rd_res_idx  (idx_r_s),
      .rd_res_ctr  (res_ctr_s)
   );

   assign pred_taken_s = run_s & pred_ctr_s[CTR_WIDTH-1];

   assign PRED_READY = run_s;
   assign PRED_TAKEN = pred_taken_s;
   assign PRED_HIST  = ghr_r;
   assign TAKE_OUT   = PC_IN_PRED + (pred_taken_s ? TAKE_OFF_IN : SKIP_OFF_IN);

   // History next-state: repair beats the speculative shift.
   always_comb begin
      ghr_nxt_s = ghr_r;
      if (RES_VALID && MISPRED) begin
         ghr_nxt_s = (RES_HIST << 1) | HIST_WIDTH'(TAKE_IN);
      end else if (PRED_VALID) begin
         ghr_nxt_s = (ghr_r << 1) | HIST_WIDTH'(pred_taken_s);
      end else begin
         ghr_nxt_s = ghr_r;
      end
   end

   // Init sweep / run FSM and history register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_INIT;
         ptr_r   <= '0;
         ghr_r   <= '0;
      end else begin
         case (state_r)
            ST_INIT: begin
               ptr_r <= ptr_r + IDX_W'(1);
               if (ptr_r == IDX_W'(NUM_ENTRIES - 1)) begin
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               ghr_r <= ghr_nxt_s;
            end
            default: begin
               state_r <= ST_INIT;
               ptr_r   <= '0;
               ghr_r   <= '0;
            end
         endcase
      end
   end

   assign unused_s = ^{PC_IN_RES, pred_ctr_s, upd_wide_s, init_wide_s};

endmodule
